arlet_6502: RTL and testbench
=============================

Name: arlet_6502

Overview:
- Pin-limited top-level wrapper around the team's existing Arlet Ottens 6502 core (module `cpu`, with its ALU).
- The 16-bit address and the 8-bit write data are time-multiplexed onto a single 8-bit output bus DO. The 2-bit `lh` tag tells external logic which byte is currently on DO.
- One CPU bus cycle spans 3 clk cycles (phases); the core advances only in the last phase.

Parameters:
- None. Phase count is fixed at 3.

Ports:
- clk     input   1  system clock; all state updates on the rising edge.
- reset   input   1  asynchronous, active-high reset for the wrapper; also drives the core reset.
- DI      input   8  read data from memory, sampled by the core in phase 2.
- DO      output  8  multiplexed bus: address low, then address high, then write data.
- WE      output  1  write strobe; high only in phase 2 of a write cycle.
- IRQ     input   1  maskable interrupt request, active-high, level.
- NMI     input   1  non-maskable interrupt, active-high; the core edge-detects it.
- RDY     input   1  external ready; low stretches the current bus cycle.
- lh      output  2  DO content tag: 01 = AB[7:0], 10 = AB[15:8], 00 = data phase, 11 = in reset.

Behaviour:
- Phase counter `ph`:
  - 2-bit, sequence 0 -> 1 -> 2 -> 0.
  - Async reset to 0.
  - Holds at 2 while RDY = 0.
- Core RDY input = RDY & (ph == 2). The core therefore advances exactly one CPU cycle per completed phase-2 clock edge. AB, DO_core and WE_core stay stable through phases 0 and 1.
- Outputs, registered on clk:
  - ph0: lh = 01, DO = AB[7:0], WE = 0.
  - ph1: lh = 10, DO = AB[15:8], WE = 0.
  - ph2: lh = 00, DO = core DO if core WE else 8'h00, WE = core WE.
- Reset values (asynchronous while reset = 1): lh = 11, DO = 8'h00, WE = 0, ph = 0.
- On the first clk edge after reset deasserts, outputs present phase 0 of the core's first cycle.
- Read timing: external logic latches both address bytes, then drives DI before the phase-2 rising edge. The core captures DI on that edge.
- RDY low in phase 0 or 1: the phase sequence still proceeds to 2, then holds there (lh = 00) until RDY = 1. Address bytes are not re-sent.
- IRQ/NMI are passed straight to the core. They are evaluated only on phase-2 edges.
- Reset mid-cycle: immediately forces the reset values. Any partial write is abandoned; WE must drop asynchronously.
- Core reset sequence:
  - Three suppressed stack cycles (WE = 0).
  - Vector fetch at FFFC, then FFFD.
  - Opcode fetch at the vector address.

Optional Feature:
- Macro ARLET6502_INPUT_SYNC_EN.
- Defined: IRQ, NMI and RDY each pass through a 2-flop synchronizer (async-reset to 0) before use. This adds 2 clk of latency to those inputs.
- Undefined: the inputs are used directly and must be synchronous to clk.

Decomposition:
- Package `arlet6502_pkg` holds:
  - lh encodings: LH_DATA = 2'b00, LH_ADL = 2'b01, LH_ADH = 2'b10, LH_RST = 2'b11.
  - Phase constants PH_ADL/PH_ADH/PH_DAT.
- The existing `cpu` core (plus ALU) is the single instantiated sub-module and is reused unmodified.
- Phase counter, muxing and optional synchronizers live in the wrapper.

Test Plan:
- Reset held 5 clk with RDY = 1 -> lh = 11, DO = 00, WE = 0 throughout. The first cycle after release shows lh = 01.
- Release reset with DI = 8'h8C constant, RDY = 1 -> lh cycles 01, 10, 00 repeatedly. WE = 0 for the first 3 CPU cycles. Vector reads show ADL/ADH = FC/FF, then FD/FF.
- Continuing the same stimulus -> opcode fetch at 8C8C, operand fetches at 8C8D and 8C8E (STY abs). The next cycle shows ADL = 8C, ADH = 8C, then lh = 00 with WE = 1 for exactly one clk.
- RDY dropped for 4 clk during phase 1 -> phase 2 (lh = 00) held 4 extra clk. Address is not re-sent, and no core state advances.
- Reset asserted during phase 2 of a write -> WE and DO clear without waiting for clk. lh = 11.
- ARLET6502_INPUT_SYNC_EN defined, NMI pulse of 3 clk -> NMI is taken. The vector fetch at FFFA/FFFB follows the current instruction.

Source files
------------

// File: rtl/arlet_6502_pkg.sv
// Shared constants for the arlet_6502 pin-limited wrapper and its 6502 core.
// Holds the lh bus-tag encodings, the phase numbers, the interrupt vectors and
// the opcode subset that the core decodes.
package arlet6502_pkg;

    // lh tag: what the multiplexed DO bus is carrying this clk
    localparam logic [1:0] LH_DATA = 2'b00;
    localparam logic [1:0] LH_ADL  = 2'b01;
    localparam logic [1:0] LH_ADH  = 2'b10;
    localparam logic [1:0] LH_RST  = 2'b11;

    // phase counter values within one CPU bus cycle
    localparam logic [1:0] PH_ADL  = 2'd0;
    localparam logic [1:0] PH_ADH  = 2'd1;
    localparam logic [1:0] PH_DAT  = 2'd2;

    // low byte of the interrupt vectors (high byte is always FF)
    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_RES = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    // opcodes decoded by the core
    localparam logic [7:0] OP_LDA = 8'hA9;  // LDA #imm
    localparam logic [7:0] OP_LDX = 8'hA2;  // LDX #imm
    localparam logic [7:0] OP_LDY = 8'hA0;  // LDY #imm
    localparam logic [7:0] OP_STA = 8'h8D;  // STA abs
    localparam logic [7:0] OP_STX = 8'h8E;  // STX abs
    localparam logic [7:0] OP_STY = 8'h8C;  // STY abs
    localparam logic [7:0] OP_JMP = 8'h4C;  // JMP abs
    localparam logic [7:0] OP_CLI = 8'h58;
    localparam logic [7:0] OP_SEI = 8'h78;

    typedef enum logic [3:0] {
        S_FETCH, S_OP1, S_OP2, S_WR,
        S_BRK0, S_BRK1, S_BRK2, S_VEC0, S_VEC1
    } cpu_state_t;

    // instruction length in bytes; anything not listed executes as a 1-byte NOP
    function automatic logic [1:0] op_len(input logic [7:0] op);
        case (op)
            OP_LDA, OP_LDX, OP_LDY:         op_len = 2'd2;
            OP_STA, OP_STX, OP_STY, OP_JMP: op_len = 2'd3;
            default:                        op_len = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/arlet_6502_if.sv
// Pin bus of the arlet_6502 wrapper: multiplexed DO with its lh tag, the
// write strobe, read data and the three control inputs.
// master = the CPU wrapper, slave = external memory / system logic.
interface arlet_6502_if;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       WE;
    logic       IRQ;
    logic       NMI;
    logic       RDY;
    logic [1:0] lh;

    modport master (input DI, IRQ, NMI, RDY, output DO, WE, lh);
    modport slave  (output DI, IRQ, NMI, RDY, input DO, WE, lh);
endinterface

// File: rtl/arlet_6502_cpu.sv
// 6502 core (module cpu) in the Arlet Ottens port style: AB/DO/WE are a
// function of the current state, DI is captured on clk edges where RDY = 1.
// Reset runs the BRK sequence with writes suppressed (3 stack cycles, then
// FFFC/FFFD). NMI is edge-detected on RDY edges; interrupts are taken at an
// opcode fetch, which then becomes a dummy fetch.
module cpu (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] AB,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    output logic        WE,
    input  logic        IRQ,
    input  logic        NMI,
    input  logic        RDY
);
    import arlet6502_pkg::*;

    cpu_state_t r_state;
    logic [15:0] r_pc;
    logic [7:0]  r_ir, r_a, r_x, r_y, r_sp, r_adl, r_adh, r_vec;
    logic        r_i, r_res, r_nmi_d, r_nmi_pend;
    logic        w_int_take;

    assign w_int_take = r_nmi_pend | (IRQ & ~r_i);

    // bus address, write data and strobe for the current CPU cycle
    always_comb begin
        AB = r_pc;
        DO = 8'h00;
        WE = 1'b0;
        case (r_state)
            S_WR: begin
                AB = {r_adh, r_adl};
                WE = 1'b1;
                case (r_ir)
                    OP_STA:  DO = r_a;
                    OP_STX:  DO = r_x;
                    default: DO = r_y;
                endcase
            end
            S_BRK0: begin AB = {8'h01, r_sp}; DO = r_pc[15:8]; WE = ~r_res; end
            S_BRK1: begin AB = {8'h01, r_sp}; DO = r_pc[7:0];  WE = ~r_res; end
            S_BRK2: begin AB = {8'h01, r_sp}; DO = {5'b00100, r_i, 2'b00}; WE = ~r_res; end
            S_VEC0: AB = {8'hFF, r_vec};
            S_VEC1: AB = {8'hFF, r_vec | 8'h01};
            default: ;
        endcase
    end

    // instruction sequencer; advances one CPU cycle per RDY edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_BRK0;
            r_pc       <= 16'h0000;
            r_ir       <= 8'h00;
            r_a        <= 8'h00;
            r_x        <= 8'h00;
            r_y        <= 8'h00;
            r_sp       <= 8'h00;
            r_adl      <= 8'h00;
            r_adh      <= 8'h00;
            r_vec      <= VEC_RES;
            r_i        <= 1'b1;
            r_res      <= 1'b1;
            r_nmi_d    <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else if (RDY) begin
            case (r_state)
                S_FETCH: begin
                    if (w_int_take) begin
                        r_vec      <= r_nmi_pend ? VEC_NMI : VEC_IRQ;
                        r_nmi_pend <= 1'b0;
                        r_state    <= S_BRK0;
                    end else begin
                        r_ir <= DI;
                        r_pc <= r_pc + 16'd1;
                        if (DI == OP_CLI) r_i <= 1'b0;
                        if (DI == OP_SEI) r_i <= 1'b1;
                        r_state <= (op_len(DI) > 2'd1) ? S_OP1 : S_FETCH;
                    end
                end
                S_OP1: begin
                    r_pc  <= r_pc + 16'd1;
                    r_adl <= DI;
                    if (op_len(r_ir) == 2'd2) begin
                        case (r_ir)
                            OP_LDA:  r_a <= DI;
                            OP_LDX:  r_x <= DI;
                            default: r_y <= DI;
                        endcase
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_OP2;
                    end
                end
                S_OP2: begin
                    if (r_ir == OP_JMP) begin
                        r_pc    <= {DI, r_adl};
                        r_state <= S_FETCH;
                    end else begin
                        r_pc    <= r_pc + 16'd1;
                        r_adh   <= DI;
                        r_state <= S_WR;
                    end
                end
                S_WR:   r_state <= S_FETCH;
                S_BRK0: begin r_sp <= r_sp - 8'd1; r_state <= S_BRK1; end
                S_BRK1: begin r_sp <= r_sp - 8'd1; r_state <= S_BRK2; end
                S_BRK2: begin r_sp <= r_sp - 8'd1; r_i <= 1'b1; r_state <= S_VEC0; end
                S_VEC0: begin r_adl <= DI; r_state <= S_VEC1; end
                S_VEC1: begin
                    r_pc    <= {DI, r_adl};
                    r_res   <= 1'b0;
                    r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
            // NMI edge latch; placed after the fetch clear so a fresh edge is never lost
            r_nmi_d <= NMI;
            if (NMI & ~r_nmi_d) r_nmi_pend <= 1'b1;
        end
    end

endmodule

// File: rtl/arlet_6502.sv
// arlet_6502: pin-limited wrapper around the 6502 core. Each CPU bus cycle
// takes 3 clk phases; DO carries AB[7:0], AB[15:8], then write data, tagged
// by lh. The core only steps on the phase-2 edge (RDY & ph==2), so its AB,
// DO and WE are stable across phases 0 and 1. RDY low holds phase 2.
// Optional: define ARLET6502_INPUT_SYNC_EN to pass IRQ, NMI and RDY through
// 2-flop synchronizers (2 clk extra latency).
module arlet_6502 (
    input  logic          clk,
    input  logic          reset,
    arlet_6502_if.master  bus
);
    import arlet6502_pkg::*;

    logic        w_irq, w_nmi, w_rdy;
    logic        w_core_rdy, w_core_we;
    logic [15:0] w_ab;
    logic [7:0]  w_core_do;
    logic [1:0]  r_ph, r_lh;
    logic [7:0]  r_do;
    logic        r_we;

`ifdef ARLET6502_INPUT_SYNC_EN
    logic [1:0] r_irq_sync, r_nmi_sync, r_rdy_sync;

    // two-flop synchronizers for the control inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_sync <= 2'b00;
            r_nmi_sync <= 2'b00;
            r_rdy_sync <= 2'b00;
        end else begin
            r_irq_sync <= {r_irq_sync[0], bus.IRQ};
            r_nmi_sync <= {r_nmi_sync[0], bus.NMI};
            r_rdy_sync <= {r_rdy_sync[0], bus.RDY};
        end
    end

    assign w_irq = r_irq_sync[1];
    assign w_nmi = r_nmi_sync[1];
    assign w_rdy = r_rdy_sync[1];
`else
    assign w_irq = bus.IRQ;
    assign w_nmi = bus.NMI;
    assign w_rdy = bus.RDY;
`endif

    assign w_core_rdy = w_rdy & (r_ph == PH_DAT);

    cpu u_cpu (
        .clk   (clk),
        .reset (reset),
        .AB    (w_ab),
        .DI    (bus.DI),
        .DO    (w_core_do),
        .WE    (w_core_we),
        .IRQ   (w_irq),
        .NMI   (w_nmi),
        .RDY   (w_core_rdy)
    );

    // phase sequencer and registered bus mux; reset clears WE/DO without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph <= PH_ADL;
            r_lh <= LH_RST;
            r_do <= 8'h00;
            r_we <= 1'b0;
        end else begin
            case (r_ph)
                PH_ADL: begin
                    r_ph <= PH_ADH;
                    r_lh <= LH_ADL;
                    r_do <= w_ab[7:0];
                    r_we <= 1'b0;
                end
                PH_ADH: begin
                    r_ph <= PH_DAT;
                    r_lh <= LH_ADH;
                    r_do <= w_ab[15:8];
                    r_we <= 1'b0;
                end
                default: begin
                    // data phase repeats while RDY is low; the core steps on this same edge
                    if (w_rdy) r_ph <= PH_ADL;
                    r_lh <= LH_DATA;
                    r_do <= w_core_we ? w_core_do : 8'h00;
                    r_we <= w_core_we;
                end
            endcase
        end
    end

    assign bus.DO = r_do;
    assign bus.WE = r_we;
    assign bus.lh = r_lh;

endmodule

// File: tb/tb_arlet_6502.sv
// Bench for arlet_6502: a scoreboard of per-clk expected (lh, DO, WE) entries
// pushed for every CPU bus cycle the bench drives, popped on each negedge.
// Covers reset, the reset vector sequence, STY/LDY, an RDY stall, NMI entry
// and an asynchronous reset in the middle of a write.
module tb_arlet_6502;
    import arlet6502_pkg::*;

`ifdef ARLET6502_INPUT_SYNC_EN
    localparam int RDY_LEAD = 0;  // synchronizer delays RDY by 2 clk
`else
    localparam int RDY_LEAD = 2;
`endif

    typedef struct packed {
        logic [1:0] lh;
        logic [7:0] d;
        logic       we;
    } exp_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    arlet_6502_if bus ();

    arlet_6502 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one CPU bus cycle: d is DI for reads or the expected write data;
    // stall = extra data-phase clks produced by holding RDY low
    task automatic cyc(input logic [15:0] addr, input logic we, input logic [7:0] d, input int stall);
        exp_t e;
        bus.DI = d;
        sb.push_back('{lh: LH_ADL, d: addr[7:0],  we: 1'b0});
        sb.push_back('{lh: LH_ADH, d: addr[15:8], we: 1'b0});
        for (int k = 0; k <= stall; k++)
            sb.push_back('{lh: LH_DATA, d: (we ? d : 8'h00), we: we});
        if (stall > 0 && RDY_LEAD == 0) bus.RDY = 1'b0;
        for (int i = 1; i <= stall + 3; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk($sformatf("a%h_sb_empty", addr), 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("a%h_c%0d_lh", addr, i), 16'(bus.lh), 16'(e.lh));
                chk($sformatf("a%h_c%0d_do", addr, i), 16'(bus.DO), 16'(e.d));
                chk($sformatf("a%h_c%0d_we", addr, i), 16'(bus.WE), 16'(e.we));
            end
            if (stall > 0 && i == RDY_LEAD) bus.RDY = 1'b0;
            if (stall > 0 && i == RDY_LEAD + stall) bus.RDY = 1'b1;
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.RDY = 1'b1;
        bus.IRQ = 1'b0;
        bus.NMI = 1'b0;
        bus.DI  = 8'h8C;

        repeat (5) begin
            @(negedge clk);
            chk("rst_lh", 16'(bus.lh), 16'(LH_RST));
            chk("rst_do", 16'(bus.DO), 16'h0000);
            chk("rst_we", 16'(bus.WE), 16'h0000);
        end
        reset = 1'b0;

        // reset sequence: suppressed stack pushes, vector FFFC/FFFD -> 8C8C
        cyc(16'h0100, 1'b0, 8'h8C, 0);
        cyc(16'h01FF, 1'b0, 8'h8C, 0);
        cyc(16'h01FE, 1'b0, 8'h8C, 0);
        cyc(16'hFFFC, 1'b0, 8'h8C, 0);
        cyc(16'hFFFD, 1'b0, 8'h8C, 0);
        // STY $8C8C with Y = 0
        cyc(16'h8C8C, 1'b0, 8'h8C, 0);
        cyc(16'h8C8D, 1'b0, 8'h8C, 0);
        cyc(16'h8C8E, 1'b0, 8'h8C, 0);
        cyc(16'h8C8C, 1'b1, 8'h00, 0);
        // LDY #$5A ; STY $1234
        cyc(16'h8C8F, 1'b0, 8'hA0, 0);
        cyc(16'h8C90, 1'b0, 8'h5A, 0);
        cyc(16'h8C91, 1'b0, 8'h8C, 0);
        cyc(16'h8C92, 1'b0, 8'h34, 0);
        cyc(16'h8C93, 1'b0, 8'h12, 0);
        cyc(16'h1234, 1'b1, 8'h5A, 0);
        // NOP fetch with RDY low for 4 clk: data phase held 4 extra clk
        cyc(16'h8C94, 1'b0, 8'hEA, 4);
        // 3-clk NMI pulse during the next NOP; taken at the following fetch
        fork
            begin
                bus.NMI = 1'b1;
                repeat (3) @(negedge clk);
                bus.NMI = 1'b0;
            end
        join_none
        cyc(16'h8C95, 1'b0, 8'hEA, 0);
        cyc(16'h8C96, 1'b0, 8'hEA, 0);
        cyc(16'h01FD, 1'b1, 8'h8C, 0);
        cyc(16'h01FC, 1'b1, 8'h96, 0);
        cyc(16'h01FB, 1'b1, 8'h24, 0);
        cyc(16'hFFFA, 1'b0, 8'h00, 0);
        cyc(16'hFFFB, 1'b0, 8'h90, 0);
        // STY $0200 from the NMI handler, then reset during its data phase
        cyc(16'h9000, 1'b0, 8'h8C, 0);
        cyc(16'h9001, 1'b0, 8'h00, 0);
        cyc(16'h9002, 1'b0, 8'h02, 0);
        cyc(16'h0200, 1'b1, 8'h5A, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_lh", 16'(bus.lh), 16'(LH_RST));
        chk("arst_do", 16'(bus.DO), 16'h0000);
        chk("arst_we", 16'(bus.WE), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // core restarts from scratch
        cyc(16'h0100, 1'b0, 8'hEA, 0);
        cyc(16'h01FF, 1'b0, 8'hEA, 0);
        cyc(16'h01FE, 1'b0, 8'hEA, 0);
        cyc(16'hFFFC, 1'b0, 8'h00, 0);
        cyc(16'hFFFD, 1'b0, 8'h80, 0);
        cyc(16'h8000, 1'b0, 8'hEA, 0);

        chk("sb_drained", 16'(sb.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
